// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - instruction handshake and bank/ALU bus of the datapath sequencer
// master is the sequencer side; slave is the surrounding datapath / instruction source.
interface datapath_sequencer_if;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  end_reg_a;
   logic [4:0]  end_reg_b;
   logic [4:0]  end_reg_c;
   logic        bank_rw;
   logic [15:0] dado_banco;
   logic [4:0]  codop;
   logic [15:0] imm;
   logic [15:0] alu_result;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [15:0] instr_count;

   modport master (
      input  instr, instr_valid, alu_result,
      output instr_ready, end_reg_a, end_reg_b, end_reg_c, bank_rw, dado_banco,
             codop, imm, busy, done, illegal, instr_count
   );

   modport slave (
      output instr, instr_valid, alu_result,
      input  instr_ready, end_reg_a, end_reg_b, end_reg_c, bank_rw, dado_banco,
             codop, imm, busy, done, illegal, instr_count
   );
endinterface

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - one-instruction-at-a-time controller for register bank and ALU
// Accepts an instruction in IDLE, waits out the ALU latency, then issues one write-back strobe.
module datapath_sequencer #(
   parameter int ALU_LATENCY = 2,
   parameter int OP_MAX      = 10,
   parameter int IMM_OP_MIN  = 6
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   datapath_sequencer_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   localparam logic [4:0] LP_OP_MAX  = 5'(OP_MAX);
   localparam logic [4:0] LP_IMM_MIN = 5'(IMM_OP_MIN);
   localparam logic [3:0] LP_WAIT    = 4'(ALU_LATENCY - 1);

   state_t      r_state;
   logic        r_ready;
   logic        r_busy;
   logic        r_done;
   logic        r_bank_rw;
   logic        r_illegal;
   logic [4:0]  r_reg_a;
   logic [4:0]  r_reg_b;
   logic [4:0]  r_reg_c;
   logic [4:0]  r_codop;
   logic [15:0] r_imm;
   logic [15:0] r_dado;
   logic [15:0] r_instr_count;
   logic [3:0]  r_wait;

   logic [4:0]  w_op;
   logic        w_legal;
   logic        w_is_imm;

   assign w_op     = {1'b0, bus.instr[15:12]};
   assign w_legal  = (w_op <= LP_OP_MAX);
   assign w_is_imm = (w_op >= LP_IMM_MIN);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state       <= S_IDLE;
         r_ready       <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_bank_rw     <= 1'b0;
         r_illegal     <= 1'b0;
         r_reg_a       <= 5'd0;
         r_reg_b       <= 5'd0;
         r_reg_c       <= 5'd0;
         r_codop       <= 5'd0;
         r_imm         <= 16'd0;
         r_dado        <= 16'd0;
         r_instr_count <= 16'd0;
         r_wait        <= 4'd0;
      end else begin
         r_done    <= 1'b0;
         r_bank_rw <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  if (w_legal) begin
                     r_reg_c <= {1'b0, bus.instr[11:8]};
                     r_reg_b <= {1'b0, bus.instr[3:0]};
                     // Immediate format reuses the ra field as imm4, so port A is parked at 0.
                     r_reg_a <= w_is_imm ? 5'd0 : {1'b0, bus.instr[7:4]};
                     r_imm   <= w_is_imm ? {12'd0, bus.instr[7:4]} : 16'd0;
                     r_codop <= w_op;
                     r_ready <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_READ;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_wait  <= LP_WAIT;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (r_wait == 4'd0) begin
                  r_dado    <= bus.alu_result;
                  r_bank_rw <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_WRITE;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            S_WRITE: begin
               r_instr_count <= r_instr_count + 16'd1;
               r_ready       <= 1'b1;
               r_busy        <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = r_ready;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.bank_rw     = r_bank_rw;
   assign bus.illegal     = r_illegal;
   assign bus.end_reg_a   = r_reg_a;
   assign bus.end_reg_b   = r_reg_b;
   assign bus.end_reg_c   = r_reg_c;
   assign bus.codop       = r_codop;
   assign bus.imm         = r_imm;
   assign bus.dado_banco  = r_dado;
   assign bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - scoreboard bench for datapath_sequencer
// Expected write-backs are queued at accept and popped on each bank_rw strobe.
module tb_datapath_sequencer;
   localparam int LAT = 2;

   typedef struct {
      logic [4:0]  c;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  codop;
      logic [15:0] imm;
      logic [15:0] dado;
      int          cyc;
   } exp_t;

   logic CLOCK_50;
   logic RESET_N;
   datapath_sequencer_if u_if();

   datapath_sequencer #(.ALU_LATENCY(LAT), .OP_MAX(10), .IMM_OP_MIN(6)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bus      (u_if)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          acc_cyc[$];
   exp_t        sb[$];
   logic [15:0] exp_count = 16'd0;
   bit          ill_pending = 0;
   bit          ill_drop = 0;
   logic [15:0] r_pipe0 = 16'd0;
   logic [15:0] r_pipe1 = 16'd0;

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [15:0] alu_model(input logic [4:0] codop, input logic [15:0] imm,
                                             input logic [4:0] a, input logic [4:0] b);
      return {codop[3:0], imm[3:0], a[3:0], b[3:0]} + 16'h0088;
   endfunction

   // Two-stage ALU model: result is only correct LAT cycles after the operands settle.
   always @(posedge CLOCK_50) begin
      cyc     <= cyc + 1;
      r_pipe0 <= alu_model(u_if.codop, u_if.imm, u_if.end_reg_a, u_if.end_reg_b);
      r_pipe1 <= r_pipe0;
   end
   assign u_if.alu_result = r_pipe1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge CLOCK_50) begin
      if (RESET_N) begin
         if (ill_drop) begin
            check("illegal_one_cycle", {31'd0, u_if.illegal}, 32'd0);
            ill_drop = 0;
         end
         if (ill_pending) begin
            check("illegal_pulse", {31'd0, u_if.illegal}, 32'd1);
            ill_pending = 0;
            ill_drop    = 1;
         end
         if (u_if.bank_rw) begin
            if (sb.size() == 0) begin
               check("rw_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wb_rc",      {27'd0, u_if.end_reg_c}, {27'd0, e.c});
               check("wb_ra",      {27'd0, u_if.end_reg_a}, {27'd0, e.a});
               check("wb_rb",      {27'd0, u_if.end_reg_b}, {27'd0, e.b});
               check("wb_codop",   {27'd0, u_if.codop},     {27'd0, e.codop});
               check("wb_imm",     {16'd0, u_if.imm},       {16'd0, e.imm});
               check("wb_data",    {16'd0, u_if.dado_banco}, {16'd0, e.dado});
               check("wb_done",    {31'd0, u_if.done},      32'd1);
               check("wb_latency", cyc - e.cyc,             LAT + 2);
               exp_count = exp_count + 16'd1;
            end
         end
         if (u_if.instr_valid && u_if.busy)
            check("ready_while_busy", {31'd0, u_if.instr_ready}, 32'd0);
         if (u_if.instr_valid && u_if.instr_ready) begin
            logic [3:0] op;
            op = u_if.instr[15:12];
            n_acc++;
            acc_cyc.push_back(cyc);
            if (op > 4'd10) begin
               ill_pending = 1;
            end else begin
               exp_t e;
               bit   is_imm;
               is_imm  = (op >= 4'd6);
               e.c     = {1'b0, u_if.instr[11:8]};
               e.b     = {1'b0, u_if.instr[3:0]};
               e.a     = is_imm ? 5'd0 : {1'b0, u_if.instr[7:4]};
               e.imm   = is_imm ? {12'd0, u_if.instr[7:4]} : 16'd0;
               e.codop = {1'b0, op};
               e.dado  = alu_model(e.codop, e.imm, e.a, e.b);
               e.cyc   = cyc;
               sb.push_back(e);
            end
         end
      end
   end

   task automatic wait_acc(input int target);
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLOCK_50); #1;
         if (n_acc >= target) begin
            got = 1;
            break;
         end
      end
      if (!got) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [15:0] w);
      int n0;
      n0 = n_acc;
      @(posedge CLOCK_50); #1;
      u_if.instr       = w;
      u_if.instr_valid = 1'b1;
      wait_acc(n0 + 1);
      u_if.instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK_50);
         if (u_if.instr_ready && !u_if.busy && sb.size() == 0) begin
            got = 1;
            break;
         end
      end
      if (!got) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   {31'd0, u_if.instr_ready}, 32'd1);
      check({tag, "_bank_rw"}, {31'd0, u_if.bank_rw},     32'd0);
      check({tag, "_busy"},    {31'd0, u_if.busy},        32'd0);
      check({tag, "_done"},    {31'd0, u_if.done},        32'd0);
      check({tag, "_illegal"}, {31'd0, u_if.illegal},     32'd0);
      check({tag, "_count"},   {16'd0, u_if.instr_count}, 32'd0);
      check({tag, "_addr"},    {17'd0, u_if.end_reg_a, u_if.end_reg_b, u_if.end_reg_c}, 32'd0);
      check({tag, "_codop"},   {27'd0, u_if.codop},       32'd0);
      check({tag, "_imm"},     {16'd0, u_if.imm},         32'd0);
      check({tag, "_dado"},    {16'd0, u_if.dado_banco},  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int n0;
      RESET_N          = 1'b0;
      u_if.instr       = 16'h0000;
      u_if.instr_valid = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_reset_outputs("reset");
      @(posedge CLOCK_50); #1;
      RESET_N = 1'b1;

      send(16'h0123);
      @(negedge CLOCK_50);
      check("accepted_busy",  {31'd0, u_if.busy},        32'd1);
      check("accepted_ready", {31'd0, u_if.instr_ready}, 32'd0);
      wait_idle();
      check("count_after_rr", {16'd0, u_if.instr_count}, 32'd1);
      check("rr_data",        {16'd0, u_if.dado_banco},  32'h00AB);

      send(16'h6A5C);
      wait_idle();
      check("imm_data",  {16'd0, u_if.dado_banco},  32'h6594);
      check("count_imm", {16'd0, u_if.instr_count}, {16'd0, exp_count});

      send(16'hB123);
      repeat (3) @(negedge CLOCK_50);
      check("illegal_count", {16'd0, u_if.instr_count}, 32'd2);
      check("illegal_rc_held", {27'd0, u_if.end_reg_c}, 32'd10);
      check("illegal_idle", {31'd0, u_if.instr_ready}, 32'd1);

      n0 = n_acc;
      @(posedge CLOCK_50); #1;
      u_if.instr       = 16'h0123;
      u_if.instr_valid = 1'b1;
      wait_acc(n0 + 1);
      u_if.instr = 16'h1456;
      wait_acc(n0 + 2);
      u_if.instr_valid = 1'b0;
      if (acc_cyc.size() >= n0 + 2)
         check("b2b_spacing", acc_cyc[n0 + 1] - acc_cyc[n0], LAT + 3);
      else
         check("b2b_accepts", acc_cyc.size(), n0 + 2);
      wait_idle();
      check("count_b2b", {16'd0, u_if.instr_count}, 32'd4);
      check("rc_b2b",    {27'd0, u_if.end_reg_c},   32'd4);

      send(16'h2345);
      @(posedge CLOCK_50); #3;
      RESET_N = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(posedge CLOCK_50);
      sb.delete();
      exp_count = 16'd0;
      #1;
      RESET_N = 1'b1;
      repeat (LAT + 4) @(negedge CLOCK_50);
      check("midreset_no_rw_count", {16'd0, u_if.instr_count}, 32'd0);

      @(negedge CLOCK_50);
      dut.r_instr_count = 16'hFFFF;
      exp_count = 16'hFFFF;
      @(negedge CLOCK_50);
      check("preload_count", {16'd0, u_if.instr_count}, 32'h0000FFFF);
      send(16'h3789);
      wait_idle();
      check("wrap_count",  {16'd0, u_if.instr_count}, 32'd0);
      check("final_count", {16'd0, u_if.instr_count}, {16'd0, exp_count});
      check("sb_empty",    sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
